cpu_run_controller: RTL and testbench

Run/halt/single-step sequencer for the CPU core. It drives the `alive` enable of the 7-phase one-hot clock sequencer and watches that sequencer's phase vector so that every stop lands on an instruction boundary. It arbitrates host run, halt and step requests, decoded HLT instructions and a single address breakpoint. It also keeps a retired-instruction counter for the debug interface.

---
 rtl/cpu_run_controller.sv | 118 +++++++++++
 tb/tb_cpu_run_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_controller.sv
// Run/halt/single-step sequencer for the CPU core.
// Gates the phase sequencer so every stop lands on an instruction boundary.
module cpu_run_controller #(
    parameter int ADDR_W   = 16,
    parameter int CNT_W    = 32,
    parameter bit BOOT_RUN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        phase,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic              halt_instr,
    input  logic [ADDR_W-1:0] next_pc,
    input  logic              bp_enable,
    input  logic [ADDR_W-1:0] bp_addr,
    output logic              alive,
    output logic              halted,
    output logic              step_done,
    output logic [2:0]        halt_cause,
    output logic [CNT_W-1:0]  instr_count
);

    localparam logic [1:0] S_HALTED = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_STEP   = 2'd2;

    localparam logic [2:0] C_RESET = 3'd0;
    localparam logic [2:0] C_HOST  = 3'd1;
    localparam logic [2:0] C_STEP  = 3'd2;
    localparam logic [2:0] C_BP    = 3'd3;
    localparam logic [2:0] C_HLT   = 3'd4;

    logic [1:0] state;
    logic       halt_pend;
    logic       commit;
    logic       bp_hit;
    logic       host_stop;
    logic       stop;
    logic [2:0] cause;

    assign commit    = alive && phase[5];
    assign bp_hit    = bp_enable && (next_pc == bp_addr);
    // A halt_req arriving on the commit cycle itself stops at that commit.
    assign host_stop = halt_pend || halt_req;

    // Stop decision and its cause, highest priority first.
    always_comb begin
        stop  = 1'b0;
        cause = C_STEP;
        if (commit) begin
            if (halt_instr) begin
                stop  = 1'b1;
                cause = C_HLT;
            end else if (bp_hit) begin
                stop  = 1'b1;
                cause = C_BP;
            end else if (host_stop) begin
                stop  = 1'b1;
                cause = C_HOST;
            end else if (state == S_STEP) begin
                stop  = 1'b1;
                cause = C_STEP;
            end
        end
    end

    // Run-state sequencing, registered outputs and retired counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT_RUN ? S_RUN : S_HALTED;
            alive       <= BOOT_RUN;
            halted      <= !BOOT_RUN;
            halt_pend   <= 1'b0;
            step_done   <= 1'b0;
            halt_cause  <= C_RESET;
            instr_count <= '0;
        end else begin
            step_done <= 1'b0;
            if (commit) begin
                instr_count <= instr_count + CNT_W'(1);
            end
            case (state)
                S_HALTED: begin
                    if (run_req) begin
                        state  <= S_RUN;
                        alive  <= 1'b1;
                        halted <= 1'b0;
                    end else if (step_req) begin
                        state  <= S_STEP;
                        alive  <= 1'b1;
                        halted <= 1'b0;
                    end
                end
                S_RUN, S_STEP: begin
                    if (stop) begin
                        state      <= S_HALTED;
                        alive      <= 1'b0;
                        halted     <= 1'b1;
                        halt_pend  <= 1'b0;
                        halt_cause <= cause;
                        step_done  <= (state == S_STEP);
                    end else if (halt_req) begin
                        halt_pend <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_HALTED;
                    alive     <= 1'b0;
                    halted    <= 1'b1;
                    halt_pend <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: stops are scored against a queue of
// expected (cause, count, step_done) records filled as stimulus is driven.
module tb_cpu_run_controller;

    typedef struct packed {
        logic [2:0]  cause;
        logic [31:0] cnt;
        logic        sd;
    } stop_t;

    logic        clk;
    logic        rst;
    logic [6:0]  phase;
    logic        run_req;
    logic        halt_req;
    logic        step_req;
    logic        halt_instr;
    logic [15:0] next_pc;
    logic        bp_enable;
    logic [15:0] bp_addr;
    logic        alive;
    logic        halted;
    logic        step_done;
    logic [2:0]  halt_cause;
    logic [31:0] instr_count;

    logic        rst0;
    logic        step0;
    logic [6:0]  ph0;
    logic        alive0;
    logic        halted0;
    logic        sd0;
    logic [2:0]  cause0;
    logic [31:0] cnt0;

    int    checks = 0;
    int    errors = 0;
    int    adv    = 0;
    int    adv_base;
    int    exp_cnt;
    logic  prev_h;
    logic  sd_seen;
    stop_t exp_q[$];

    cpu_run_controller #(.ADDR_W(16), .CNT_W(32), .BOOT_RUN(1'b1)) u_run (
        .clk(clk), .rst(rst), .phase(phase),
        .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
        .halt_instr(halt_instr), .next_pc(next_pc),
        .bp_enable(bp_enable), .bp_addr(bp_addr),
        .alive(alive), .halted(halted), .step_done(step_done),
        .halt_cause(halt_cause), .instr_count(instr_count)
    );

    cpu_run_controller #(.ADDR_W(16), .CNT_W(32), .BOOT_RUN(1'b0)) u_boot0 (
        .clk(clk), .rst(rst0), .phase(ph0),
        .run_req(1'b0), .halt_req(1'b0), .step_req(step0),
        .halt_instr(1'b0), .next_pc(16'h0000),
        .bp_enable(1'b0), .bp_addr(16'h0000),
        .alive(alive0), .halted(halted0), .step_done(sd0),
        .halt_cause(cause0), .instr_count(cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Phase sequencer model: advances while alive, always finishes
    // the rotation back to phase0, then parks there.
    always @(posedge clk) begin
        if (rst) begin
            phase <= 7'h01;
        end else if (alive || phase != 7'h01) begin
            phase <= {phase[5:0], phase[6]};
            adv   <= adv + 1;
        end
    end

    always @(posedge clk) begin
        if (rst0) ph0 <= 7'h01;
        else if (alive0 || ph0 != 7'h01) ph0 <= {ph0[5:0], ph0[6]};
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [2:0] c, input logic [31:0] n,
                        input logic s);
        stop_t e;
        e.cause = c;
        e.cnt   = n;
        e.sd    = s;
        exp_q.push_back(e);
    endtask

    task automatic wait_ph(input int b);
        int n = 0;
        while (!phase[b] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!phase[b]) chk("wait_phase", {25'd0, phase}, 32'(1) << b);
    endtask

    task automatic wait_halt();
        int n = 0;
        while (!halted && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!halted) chk("wait_halt", halted, 1);
    endtask

    // Scoreboard: every rise of halted consumes one expected stop record.
    always @(negedge clk) begin
        if (!rst && halted && !prev_h) begin
            if (exp_q.size() == 0) begin
                chk("spurious_stop", halted, 0);
            end else begin
                chk("sb_cause", halt_cause, exp_q[0].cause);
                chk("sb_count", instr_count, exp_q[0].cnt);
                chk("sb_step_done", step_done, exp_q[0].sd);
                exp_q.delete(0);
            end
        end
        prev_h <= halted;
    end

    initial begin
        rst = 1'b1; rst0 = 1'b1;
        run_req = 0; halt_req = 0; step_req = 0; step0 = 0;
        halt_instr = 0; next_pc = 16'h0010;
        bp_enable = 0; bp_addr = 16'h0040;
        repeat (3) @(negedge clk);
        chk("rst_alive", alive, 1);
        chk("rst_halted", halted, 0);
        chk("rst_cause", halt_cause, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_step_done", step_done, 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            wait_ph(5);
            @(negedge clk);
        end
        exp_cnt = 10;
        chk("boot_count", instr_count, exp_cnt);
        chk("boot_alive", alive, 1);
        chk("boot_cause", halt_cause, 0);

        wait_ph(2);
        exp_cnt++;
        push(3'd1, exp_cnt, 1'b0);
        halt_req = 1;
        @(negedge clk);
        halt_req = 0;
        wait_halt();
        repeat (2) @(negedge clk);
        chk("halt_phase_hold", {25'd0, phase}, 32'h01);
        chk("halt_count_hold", instr_count, exp_cnt);

        adv_base = adv;
        exp_cnt++;
        push(3'd2, exp_cnt, 1'b1);
        step_req = 1;
        @(negedge clk);
        step_req = 0;
        wait_halt();
        repeat (3) @(negedge clk);
        chk("step_rotation", adv - adv_base, 7);
        chk("step_halted", halted, 1);
        chk("step_done_clr", step_done, 0);

        bp_enable = 1; bp_addr = 16'h0040; next_pc = 16'h0040;
        exp_cnt++;
        push(3'd3, exp_cnt, 1'b0);
        run_req = 1;
        @(negedge clk);
        run_req = 0;
        wait_halt();
        next_pc = 16'h0041;
        run_req = 1;
        @(negedge clk);
        run_req = 0;
        wait_ph(5);
        @(negedge clk);
        wait_ph(5);
        @(negedge clk);
        exp_cnt += 2;
        chk("bp_rearm_run", halted, 0);
        chk("bp_rearm_count", instr_count, exp_cnt);

        halt_instr = 1; next_pc = 16'h0040;
        wait_ph(5);
        exp_cnt++;
        push(3'd4, exp_cnt, 1'b0);
        halt_req = 1;
        @(negedge clk);
        halt_req = 0;
        halt_instr = 0;
        wait_halt();
        next_pc = 16'h0041;
        run_req = 1;
        @(negedge clk);
        run_req = 0;
        wait_ph(5);
        @(negedge clk);
        exp_cnt++;
        chk("pend_cleared", halted, 0);
        chk("pend_count", instr_count, exp_cnt);

        wait_ph(2);
        exp_cnt++;
        push(3'd1, exp_cnt, 1'b0);
        halt_req = 1;
        @(negedge clk);
        halt_req = 0;
        wait_halt();
        run_req = 1; step_req = 1;
        @(negedge clk);
        run_req = 0; step_req = 0;
        sd_seen = 0;
        for (int i = 0; i < 16; i++) begin
            sd_seen |= step_done;
            @(negedge clk);
        end
        chk("runstep_running", alive, 1);
        chk("runstep_no_sd", sd_seen, 0);
        chk("sb_drain", exp_q.size(), 0);

        rst0 = 1'b0;
        @(negedge clk);
        chk("b0_halted", halted0, 1);
        chk("b0_alive", alive0, 0);
        step0 = 1;
        @(negedge clk);
        step0 = 0;
        sd_seen = 0;
        for (int i = 0; i < 12; i++) begin
            sd_seen |= sd0;
            @(negedge clk);
        end
        chk("b0_step_count", cnt0, 1);
        chk("b0_step_cause", cause0, 2);
        chk("b0_step_sd", sd_seen, 1);
        step0 = 1;
        @(negedge clk);
        step0 = 0;
        for (int i = 0; i < 20 && !ph0[3]; i++) @(negedge clk);
        chk("b0_mid_phase3", ph0[3], 1);
        rst0 = 1'b1;
        @(negedge clk);
        chk("b0_rst_halted", halted0, 1);
        chk("b0_rst_alive", alive0, 0);
        chk("b0_rst_sd", sd0, 0);
        chk("b0_rst_count", cnt0, 0);
        rst0 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
